// File: rtl/shifter_left_seq_if.sv
// Handshake/data bundle for shifter_left_seq: start/data/shamt/rot in,
// busy/done/dataOut back. master = requester (EX stage), slave = shifter.
interface shifter_left_seq_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] shamt;
  logic               rot;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dataOut;

  modport master (output start, data, shamt, rot, input  busy, done, dataOut);
  modport slave  (input  start, data, shamt, rot, output busy, done, dataOut);
endinterface

// File: rtl/shifter_left_seq.sv
// shifter_left_seq: multi-cycle 32-bit logical left shifter.
// One binary stage (16/8/4/2/1) per clock, then a terminal cycle and a
// single DONE cycle, giving a 7-cycle start-to-start interval.
// Optional feature macro: SHIFTER_ROTATE_EN (rot=1 turns active stages
// into rotate-left). Without it rot is ignored and the port list is unchanged.
module shifter_left_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  shifter_left_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               rot_q, rot_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;

  logic               stage_on;
  logic [WIDTH-1:0]   stage_shl;
  logic [WIDTH-1:0]   stage_rol;

  // Stage select: cnt 0..4 maps to shift distance 16>>cnt, gated by shamt[4-cnt].
  always_comb begin
    stage_on  = 1'b0;
    stage_shl = work_q;
    stage_rol = work_q;
    case (cnt_q)
      3'd0: begin
        stage_on  = shamt_q[4];
        stage_shl = {work_q[WIDTH-17:0], 16'h0};
        stage_rol = {work_q[WIDTH-17:0], work_q[WIDTH-1:WIDTH-16]};
      end
      3'd1: begin
        stage_on  = shamt_q[3];
        stage_shl = {work_q[WIDTH-9:0], 8'h0};
        stage_rol = {work_q[WIDTH-9:0], work_q[WIDTH-1:WIDTH-8]};
      end
      3'd2: begin
        stage_on  = shamt_q[2];
        stage_shl = {work_q[WIDTH-5:0], 4'h0};
        stage_rol = {work_q[WIDTH-5:0], work_q[WIDTH-1:WIDTH-4]};
      end
      3'd3: begin
        stage_on  = shamt_q[1];
        stage_shl = {work_q[WIDTH-3:0], 2'b0};
        stage_rol = {work_q[WIDTH-3:0], work_q[WIDTH-1:WIDTH-2]};
      end
      3'd4: begin
        stage_on  = shamt_q[0];
        stage_shl = {work_q[WIDTH-2:0], 1'b0};
        stage_rol = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      end
      default: ;
    endcase
  end

  // FSM next state: latch operands in IDLE, step stages in SHIFT,
  // publish the result on the edge into DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    shamt_d    = shamt_q;
    rot_d      = rot_q;
    data_out_d = data_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.data;
          shamt_d = bus.shamt;
`ifdef SHIFTER_ROTATE_EN
          rot_d   = bus.rot;
`else
          rot_d   = 1'b0;
`endif
          cnt_d   = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // cnt==5 is the terminal cycle after the last stage; the extra
        // cycle keeps the issue interval the stall logic is built around.
        if (cnt_q == 3'd5) begin
          data_out_d = work_q;
          state_d    = S_DONE;
        end else begin
          if (stage_on) work_d = rot_q ? stage_rol : stage_shl;
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight shift and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      work_q     <= '0;
      shamt_q    <= '0;
      rot_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      shamt_q    <= shamt_d;
      rot_q      <= rot_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.dataOut = data_out_q;

endmodule

// File: tb/tb_shifter_left_seq.sv
// Scoreboard bench for shifter_left_seq: stimulus pushes expected result and
// expected done cycle; a negedge monitor pops and compares on every done.
module tb_shifter_left_seq;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  shifter_left_seq_if bus ();

  shifter_left_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, bus.done}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dataOut", bus.dataOut, e.val);
        chk("done_latency", cyc, e.cyc);
      end
    end
  end

  // Drive one start pulse at a negedge; optionally register its expectation.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic r,
                       input logic [31:0] exp, input bit track);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = d;
    bus.shamt = s;
    bus.rot   = r;
    e.val = exp;
    e.cyc = cyc + 7;
    if (track) sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.data  = 32'hDEAD_BEEF;
    bus.shamt = 5'd31;
    bus.rot   = 1'b0;
    chk("busy_after_start", {31'b0, bus.busy}, 32'h1);
  endtask

  // Wait for the scoreboard to empty, then one more cycle so the DUT is idle.
  task automatic drain(input logic [31:0] hold_val);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 30) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'h0);
      sb.delete();
    end
    @(negedge clk);
    chk("idle_busy", {31'b0, bus.busy}, 32'h0);
    repeat (2) @(negedge clk);
    chk("dataOut_hold", bus.dataOut, hold_val);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0;
    bus.data  = 32'h0;
    bus.shamt = 5'd0;
    bus.rot   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    chk("reset_done", {31'b0, bus.done}, 32'h0);
    chk("reset_dataOut", bus.dataOut, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_busy", {31'b0, bus.busy}, 32'h0);
      chk("idle_done", {31'b0, bus.done}, 32'h0);
      chk("idle_dataOut", bus.dataOut, 32'h0);
    end

    // Basic and boundary vectors
    issue(32'h0000_00FF, 5'd8,  1'b0, 32'h0000_FF00, 1'b1); drain(32'h0000_FF00);
    issue(32'hFFFF_FFFF, 5'd31, 1'b0, 32'h8000_0000, 1'b1); drain(32'h8000_0000);
    issue(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b1); drain(32'h1234_5678);
    issue(32'h0000_0001, 5'd21, 1'b0, 32'h0020_0000, 1'b1); drain(32'h0020_0000);

    // Start while busy is dropped: only the first request completes
    issue(32'h0000_0001, 5'd1, 1'b0, 32'h0000_0002, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.data  = 32'h0000_0001;
    bus.shamt = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    drain(32'h0000_0002);
    issue(32'h0000_0003, 5'd5, 1'b0, 32'h0000_0060, 1'b1); drain(32'h0000_0060);

    // Reset in SHIFT cycle 3 aborts with no done and clears dataOut
    issue(32'hA5A5_A5A5, 5'd3, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'h0);
    chk("abort_dataOut", bus.dataOut, 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_dataOut_stays", bus.dataOut, 32'h0);
    issue(32'hA5A5_A5A5, 5'd3, 1'b0, 32'h2D2D_2D28, 1'b1); drain(32'h2D2D_2D28);

    // Rotate request: rotates only when the feature is built in
`ifdef SHIFTER_ROTATE_EN
    issue(32'h8000_0001, 5'd4, 1'b1, 32'h0000_0018, 1'b1); drain(32'h0000_0018);
`else
    issue(32'h8000_0001, 5'd4, 1'b1, 32'h0000_0010, 1'b1); drain(32'h0000_0010);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
